// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS main control FSM.
// The master is the controller; the slave is the datapath that consumes its selects.
interface multicycle_control_if;
    logic [5:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  Op, Zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state
    );

    modport slave (
        output Op, Zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with Moore-decoded selects and mem_ready-stalled memory states.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t st, ds;

    always_ff @(posedge clk) begin
        if (reset) st <= FETCH;
        else begin
            case (st)
                FETCH:   if (bus.mem_ready) st <= DECODE;
                DECODE: begin
                    case (bus.Op)
                        OP_LW, OP_SW: st <= MEMADR;
                        OP_RTYPE:     st <= EXECUTE;
                        OP_BEQ:       st <= BRANCH;
                        OP_ADDI:      st <= ADDIEX;
                        OP_J:         st <= JUMP;
                        default:      st <= FETCH;
                    endcase
                end
                MEMADR:  st <= (bus.Op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (bus.mem_ready) st <= MEMWB;
                MEMWR:   if (bus.mem_ready) st <= FETCH;
                EXECUTE: st <= ALUWB;
                BRANCH:  st <= FETCH;
                ADDIEX:  st <= ADDIWB;
                default: st <= FETCH;
            endcase
        end
    end

    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcwrite, branch, illegal;

    // Decoding FETCH under reset keeps the datapath selects benign while an
    // interrupted instruction is abandoned; the enables are then squashed below.
    always_comb begin
        ds       = reset ? FETCH : st;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        illegal  = 1'b0;
        case (ds)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = bus.mem_ready;
                pcwrite = bus.mem_ready;
            end
            DECODE: begin
                alusrcb = 2'b11;
                illegal = !(bus.Op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
            branch   = 1'b0;
        end
    end

    assign bus.IorD       = iord;
    assign bus.MemWrite   = memwrite;
    assign bus.IRWrite    = irwrite;
    assign bus.RegDst     = regdst;
    assign bus.MemtoReg   = memtoreg;
    assign bus.RegWrite   = regwrite;
    assign bus.ALUSrcA    = alusrca;
    assign bus.ALUSrcB    = alusrcb;
    assign bus.ALUOp      = aluop;
    assign bus.PCSrc      = pcsrc;
    assign bus.PCEn       = pcwrite | (branch & bus.Zero);
    assign bus.illegal_op = illegal;
    assign bus.state      = st;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: each vector drives the inputs for one
// cycle and checks the state plus the full packed output word against hand-computed values.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus ();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    // {IorD,MemWrite,IRWrite, RegDst,MemtoReg,RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn,illegal_op}
    logic [14:0] outs;
    assign outs = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                   bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.PCEn, bus.illegal_op};

    localparam logic [14:0] O_FETCH1 = 15'b001_000_0_01_00_00_10;
    localparam logic [14:0] O_FETCH0 = 15'b000_000_0_01_00_00_00;
    localparam logic [14:0] O_RST    = 15'b000_000_0_01_00_00_00;
    localparam logic [14:0] O_DEC    = 15'b000_000_0_11_00_00_00;
    localparam logic [14:0] O_DECILL = 15'b000_000_0_11_00_00_01;
    localparam logic [14:0] O_MEMADR = 15'b000_000_1_10_00_00_00;
    localparam logic [14:0] O_MEMRD  = 15'b100_000_0_00_00_00_00;
    localparam logic [14:0] O_MEMWB  = 15'b000_011_0_00_00_00_00;
    localparam logic [14:0] O_MEMWR  = 15'b110_000_0_00_00_00_00;
    localparam logic [14:0] O_EXE    = 15'b000_000_1_00_10_00_00;
    localparam logic [14:0] O_ALUWB  = 15'b000_101_0_00_00_00_00;
    localparam logic [14:0] O_BEQT   = 15'b000_000_1_00_01_01_10;
    localparam logic [14:0] O_BEQN   = 15'b000_000_1_00_01_01_00;
    localparam logic [14:0] O_ADDIEX = 15'b000_000_1_10_00_00_00;
    localparam logic [14:0] O_ADDIWB = 15'b000_001_0_00_00_00_00;
    localparam logic [14:0] O_JUMP   = 15'b000_000_0_00_00_10_10;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, ILL = 6'b111111;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs, let the decode settle, check, then advance past the edge.
    task automatic vec(input string tag, input logic [5:0] op, input logic z, input logic rdy,
                       input logic rst, input logic [3:0] es, input logic [14:0] eo);
        bus.Op = op; bus.Zero = z; bus.mem_ready = rdy; reset = rst;
        #1;
        chk({tag, ".state"}, {28'd0, bus.state}, {28'd0, es});
        chk({tag, ".outs"}, {17'd0, outs}, {17'd0, eo});
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; bus.Op = R; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec("rst",      R, 0, 1, 1, 4'd0,  O_RST);

        vec("r.fetch",  R, 0, 1, 0, 4'd0,  O_FETCH1);
        vec("r.dec",    R, 0, 1, 0, 4'd1,  O_DEC);
        vec("r.exe",    R, 0, 1, 0, 4'd6,  O_EXE);
        vec("r.wb",     R, 0, 1, 0, 4'd7,  O_ALUWB);

        vec("lw.fetch", LW, 0, 1, 0, 4'd0, O_FETCH1);
        vec("lw.dec",   LW, 0, 1, 0, 4'd1, O_DEC);
        vec("lw.adr",   LW, 0, 1, 0, 4'd2, O_MEMADR);
        vec("lw.rd0",   LW, 0, 0, 0, 4'd3, O_MEMRD);
        vec("lw.rd1",   LW, 0, 0, 0, 4'd3, O_MEMRD);
        vec("lw.rd2",   LW, 0, 1, 0, 4'd3, O_MEMRD);
        vec("lw.wb",    LW, 0, 1, 0, 4'd4, O_MEMWB);

        vec("sw.stall0", SW, 0, 0, 0, 4'd0, O_FETCH0);
        vec("sw.stall1", SW, 0, 0, 0, 4'd0, O_FETCH0);
        vec("sw.stall2", SW, 0, 0, 0, 4'd0, O_FETCH0);
        vec("sw.fetch",  SW, 0, 1, 0, 4'd0, O_FETCH1);
        vec("sw.dec",    SW, 0, 1, 0, 4'd1, O_DEC);
        vec("sw.adr",    SW, 0, 1, 0, 4'd2, O_MEMADR);
        vec("sw.wr",     SW, 0, 1, 0, 4'd5, O_MEMWR);

        // Park in MEMWR with the memory stalled, then reset mid-store.
        vec("rsw.fetch", SW, 0, 1, 0, 4'd0, O_FETCH1);
        vec("rsw.dec",   SW, 0, 1, 0, 4'd1, O_DEC);
        vec("rsw.adr",   SW, 0, 1, 0, 4'd2, O_MEMADR);
        vec("rsw.wr",    SW, 0, 0, 0, 4'd5, O_MEMWR);
        vec("rsw.rst0",  SW, 1, 1, 1, 4'd5, O_RST);
        vec("rsw.rst1",  SW, 1, 1, 1, 4'd0, O_RST);

        vec("bt.fetch", BEQ, 1, 1, 0, 4'd0, O_FETCH1);
        vec("bt.dec",   BEQ, 1, 1, 0, 4'd1, O_DEC);
        vec("bt.br",    BEQ, 1, 1, 0, 4'd8, O_BEQT);
        vec("bn.fetch", BEQ, 0, 1, 0, 4'd0, O_FETCH1);
        vec("bn.dec",   BEQ, 0, 1, 0, 4'd1, O_DEC);
        vec("bn.br",    BEQ, 0, 1, 0, 4'd8, O_BEQN);

        vec("j.fetch",  J, 0, 1, 0, 4'd0,  O_FETCH1);
        vec("j.dec",    J, 0, 1, 0, 4'd1,  O_DEC);
        vec("j.jump",   J, 0, 1, 0, 4'd11, O_JUMP);

        vec("ai.fetch", ADDI, 0, 1, 0, 4'd0,  O_FETCH1);
        vec("ai.dec",   ADDI, 0, 1, 0, 4'd1,  O_DEC);
        vec("ai.ex",    ADDI, 0, 1, 0, 4'd9,  O_ADDIEX);
        vec("ai.wb",    ADDI, 0, 1, 0, 4'd10, O_ADDIWB);

        vec("ill.fetch", ILL, 0, 1, 0, 4'd0, O_FETCH1);
        vec("ill.dec",   ILL, 0, 1, 0, 4'd1, O_DECILL);
        vec("ill.back",  ILL, 0, 0, 0, 4'd0, O_FETCH0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
